// File: rtl/sevenseg_pkg.sv
// Shared constants and types for 7-segment scan monitors: active-low glyphs,
// one-hot digit selects and the frame-collection state encoding.
package sevenseg_pkg;

  // Active-low glyphs, bit7..bit1 = a..g, bit0 = dp (held off here).
  localparam logic [7:0] SEG_0     = 8'h03;
  localparam logic [7:0] SEG_1     = 8'h9F;
  localparam logic [7:0] SEG_2     = 8'h25;
  localparam logic [7:0] SEG_3     = 8'h0D;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h49;
  localparam logic [7:0] SEG_6     = 8'h41;
  localparam logic [7:0] SEG_7     = 8'h1F;
  localparam logic [7:0] SEG_8     = 8'h01;
  localparam logic [7:0] SEG_9     = 8'h19;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [3:0] AN_HT = 4'b0001;
  localparam logic [3:0] AN_HO = 4'b0010;
  localparam logic [3:0] AN_MT = 4'b0100;
  localparam logic [3:0] AN_MO = 4'b1000;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    COLLECT = 2'd1,
    CHECK   = 2'd2
  } scan_state_t;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/sevenseg_glyph_dec.sv
// Combinational glyph decoder: segments a..g (active-low) to a BCD digit,
// flagging any pattern that is not one of the ten digit glyphs.
module sevenseg_glyph_dec
  import sevenseg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] digit,
  output logic       illegal
);

  always_comb begin
    digit   = 4'd0;
    illegal = 1'b0;
    case (seg)
      SEG_0[7:1]: digit = 4'd0;
      SEG_1[7:1]: digit = 4'd1;
      SEG_2[7:1]: digit = 4'd2;
      SEG_3[7:1]: digit = 4'd3;
      SEG_4[7:1]: digit = 4'd4;
      SEG_5[7:1]: digit = 4'd5;
      SEG_6[7:1]: digit = 4'd6;
      SEG_7[7:1]: digit = 4'd7;
      SEG_8[7:1]: digit = 4'd8;
      SEG_9[7:1]: digit = 4'd9;
      default:    illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/sevenseg_scan_decoder.sv
// Reconstructs HH:MM from a multiplexed 4-digit 7-segment bus.
// Optional build macro ERR_COUNT_EN adds a saturating rejected-frame counter.
module sevenseg_scan_decoder
  import sevenseg_pkg::*;
#(
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 65536
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] an_in,
  input  logic [7:0] seg_in,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic       frame_valid,
  output logic       frame_err,
  output logic       link_lost
`ifdef ERR_COUNT_EN
  ,
  output logic [7:0] err_count
`endif
);

  localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [3:0]  SETTLE_PRE  = 4'(SETTLE - 2);
  localparam logic [16:0] TO_LAST     = 17'(TIMEOUT - 1);

  logic [3:0]  an_s1, an_s2;
  logic [7:0]  seg_s1, seg_s2;
  logic [11:0] sample, sample_prev;
  logic [3:0]  settle_cnt;
  logic        changed, accept;

  logic [3:0]  dig;
  logic        illegal;

  scan_state_t state, state_next;
  logic [3:0]  mask, mask_next;
  logic        err_flag, err_next;
  logic        wr_en, check_ok, check_fail;
  logic [3:0]  digits [4];
  logic [7:0]  hr_sum, min_sum;
  logic        range_ok;
  logic [16:0] to_cnt;

  assign sample  = {an_s2, seg_s2};
  assign changed = (sample != sample_prev);
  // Accept on the cycle the settle counter steps onto its last value; it then parks.
  assign accept  = !changed && (settle_cnt == SETTLE_PRE) && is_onehot4(an_s2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_s1       <= '0;
      an_s2       <= '0;
      seg_s1      <= '0;
      seg_s2      <= '0;
      sample_prev <= '0;
      settle_cnt  <= '0;
    end else begin
      an_s1       <= an_in;
      an_s2       <= an_s1;
      seg_s1      <= seg_in;
      seg_s2      <= seg_s1;
      sample_prev <= sample;
      if (changed)
        settle_cnt <= '0;
      else if (settle_cnt != SETTLE_LAST)
        settle_cnt <= settle_cnt + 4'd1;
    end
  end

  sevenseg_glyph_dec u_glyph_dec (
    .seg     (seg_s2[7:1]),
    .digit   (dig),
    .illegal (illegal)
  );

  // ht*10 built from shifts in a wide sum so the range check sees the true value.
  assign hr_sum   = ({4'd0, digits[0]} << 3) + ({4'd0, digits[0]} << 1) + {4'd0, digits[1]};
  assign min_sum  = ({4'd0, digits[2]} << 3) + ({4'd0, digits[2]} << 1) + {4'd0, digits[3]};
  assign range_ok = (digits[0] <= 4'd2) && (hr_sum <= 8'd23) && (digits[2] <= 4'd5);

  always_comb begin
    state_next = state;
    mask_next  = mask;
    err_next   = err_flag;
    wr_en      = 1'b0;
    check_ok   = 1'b0;
    check_fail = 1'b0;
    case (state)
      HUNT: begin
        if (accept && an_s2 == AN_HT) begin
          state_next = COLLECT;
          mask_next  = AN_HT;
          err_next   = illegal;
          wr_en      = 1'b1;
        end
      end
      COLLECT: begin
        if (accept) begin
          if ((mask & an_s2) != 4'd0) begin
            // A repeated hour-tens slot is a fresh frame start; any other repeat drops the frame.
            if (an_s2 == AN_HT) begin
              mask_next = AN_HT;
              err_next  = illegal;
              wr_en     = 1'b1;
            end else begin
              state_next = HUNT;
              mask_next  = '0;
              err_next   = 1'b0;
            end
          end else begin
            mask_next = mask | an_s2;
            err_next  = err_flag | illegal;
            wr_en     = 1'b1;
            if ((mask | an_s2) == 4'b1111)
              state_next = CHECK;
          end
        end
      end
      CHECK: begin
        state_next = HUNT;
        mask_next  = '0;
        err_next   = 1'b0;
        if (!err_flag && range_ok)
          check_ok = 1'b1;
        else
          check_fail = 1'b1;
      end
      default: begin
        state_next = HUNT;
        mask_next  = '0;
        err_next   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HUNT;
      mask     <= '0;
      err_flag <= 1'b0;
      for (int i = 0; i < 4; i++)
        digits[i] <= '0;
    end else begin
      state    <= state_next;
      mask     <= mask_next;
      err_flag <= err_next;
      for (int i = 0; i < 4; i++)
        if (wr_en && an_s2[i])
          digits[i] <= dig;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hours       <= '0;
      minutes     <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      link_lost   <= 1'b0;
      to_cnt      <= '0;
    end else begin
      frame_valid <= check_ok;
      frame_err   <= check_fail;
      if (check_ok) begin
        hours     <= hr_sum[4:0];
        minutes   <= min_sum[5:0];
        to_cnt    <= '0;
        link_lost <= 1'b0;
      end else if (to_cnt == TO_LAST) begin
        link_lost <= 1'b1;
      end else begin
        to_cnt <= to_cnt + 17'd1;
      end
    end
  end

`ifdef ERR_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_count <= '0;
    else if (check_fail && err_count != 8'hFF)
      err_count <= err_count + 8'd1;
  end
`endif

endmodule
